// File: rtl/ring_count_checker.sv
// Cycle-accurate checker for a loadable ring counter: mirrors load/reset/rotate in a
// reference model and compares the observed count. Define RING_CHECK_DISPLAY_EN for sim messages.
module ring_count_checker #(
    parameter int WIDTH     = 4,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             dut_reset,
    input  logic             step,
    input  logic             mod,
    input  logic             check,
    input  logic [WIDTH-1:0] count_obs,
    output logic [WIDTH-1:0] exp,
    output logic             mismatch,
    output logic [7:0]       err_count,
    output logic [15:0]      sample_count,
    output logic             synced,
    output logic             fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] EXP_RST   = WIDTH'(1);
    localparam logic [7:0]       LIMIT     = 8'(ERR_LIMIT);

    state_t           state;
    logic [WIDTH-1:0] exp_next;
    logic [7:0]       err_inc;
    logic             miscmp;

    // The model follows the counter in every state, including FAULT.
    always_comb begin
        exp_next = exp;
        if (load)
            exp_next = data;
        else if (dut_reset)
            exp_next = EXP_RST;
        else if (step)
            exp_next = mod ? {exp[WIDTH-2:0], exp[WIDTH-1]}
                           : {exp[0], exp[WIDTH-1:1]};
    end

    assign err_inc = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
    assign miscmp  = (count_obs != exp);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            exp          <= EXP_RST;
            mismatch     <= 1'b0;
            err_count    <= 8'd0;
            sample_count <= 16'd0;
            synced       <= 1'b0;
            fault        <= 1'b0;
        end else begin
            exp      <= exp_next;
            mismatch <= 1'b0;
            case (state)
                IDLE: begin
                    if (load || dut_reset) begin
                        state  <= TRACK;
                        synced <= 1'b1;
                    end
                end
                TRACK: begin
                    // Compare against the value held before this cycle's model update.
                    if (check) begin
                        sample_count <= sample_count + 16'd1;
                        if (miscmp) begin
                            mismatch  <= 1'b1;
                            err_count <= err_inc;
`ifdef RING_CHECK_DISPLAY_EN
                            $display("%0t ring_count_checker: miscompare exp=%b obs=%b",
                                     $time, exp, count_obs);
`endif
                            if (err_inc >= LIMIT) begin
                                state <= FAULT;
                                fault <= 1'b1;
`ifdef RING_CHECK_DISPLAY_EN
                                $display("%0t ring_count_checker: entering fault, err_count=%0d",
                                         $time, err_inc);
`endif
                            end
                        end
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state  <= IDLE;
                    synced <= 1'b0;
                    fault  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_count_checker.sv
// Randomized bench for ring_count_checker against an arithmetic reference model.
module tb_ring_count_checker;

    localparam int W     = 4;
    localparam int LIMIT = 4;
    localparam int MODV  = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] data = '0;
    logic         dut_reset = 1'b0;
    logic         step = 1'b0;
    logic         mod = 1'b0;
    logic         check = 1'b0;
    logic [W-1:0] count_obs = '0;
    logic [W-1:0] exp;
    logic         mismatch;
    logic [7:0]   err_count;
    logic [15:0]  sample_count;
    logic         synced;
    logic         fault;

    ring_count_checker #(.WIDTH(W), .ERR_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .load(load), .data(data), .dut_reset(dut_reset),
        .step(step), .mod(mod), .check(check), .count_obs(count_obs), .exp(exp),
        .mismatch(mismatch), .err_count(err_count), .sample_count(sample_count),
        .synced(synced), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0 = not yet synced, 1 = tracking, 2 = faulted.
    int m_exp = 1, m_mode = 0, m_err = 0, m_samp = 0, m_mis = 0;

    task automatic chk(input string tag, input int obs, input int want);
        n_vec++;
        if (obs != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic int rot(input int v, input bit left);
        if (left) return ((v * 2) % MODV) + (v / (MODV / 2));
        else      return (v / 2) + ((v % 2) * (MODV / 2));
    endfunction

    function automatic void model_update();
        m_mis = 0;
        if (reset) begin
            m_exp = 1; m_mode = 0; m_err = 0; m_samp = 0;
            return;
        end
        if (m_mode == 0) begin
            if (load || dut_reset) m_mode = 1;
        end else if (m_mode == 1 && check) begin
            m_samp = (m_samp + 1) % 65536;
            if (int'(count_obs) != m_exp) begin
                m_mis = 1;
                m_err = (m_err < 255) ? m_err + 1 : 255;
                if (m_err >= LIMIT) m_mode = 2;
            end
        end
        if (load)           m_exp = int'(data);
        else if (dut_reset) m_exp = 1;
        else if (step)      m_exp = rot(m_exp, mod);
    endfunction

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        chk("exp", int'(exp), m_exp);
        chk("mismatch", int'(mismatch), m_mis);
        chk("err_count", int'(err_count), m_err);
        chk("sample_count", int'(sample_count), m_samp);
        chk("synced", int'(synced), int'(m_mode != 0));
        chk("fault", int'(fault), int'(m_mode == 2));
    endtask

    task automatic drive(input bit r, input bit l, input int d, input bit dr,
                         input bit s, input bit m, input bit c, input int o);
        reset = r; load = l; data = W'(d); dut_reset = dr;
        step = s; mod = m; check = c; count_obs = W'(o);
        cycle();
    endtask

    initial begin
        int mis_seen;
        // Reset, then checks in IDLE are ignored.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_exp", int'(exp), 1);
        chk("rst_err", int'(err_count), 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("idle_samples", int'(sample_count), 0);
        chk("idle_synced", int'(synced), 0);
        chk("idle_exp", int'(exp), 1);

        // Left rotation walk: step, then check the new value next cycle.
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        mis_seen = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 1, 0, 0);
            drive(0, 0, 0, 0, 0, 0, 1, 2 ** ((i + 1) % 4));
            mis_seen += int'(mismatch);
        end
        chk("walk_samples", int'(sample_count), 4);
        chk("walk_err", int'(err_count), 0);
        chk("walk_mis", mis_seen, 0);

        // Load then right step; same-cycle check sees the loaded value.
        drive(0, 1, 4'b1010, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 1, 4'b1010);
        chk("same_cyc_pass", int'(mismatch), 0);
        chk("rot_right", int'(exp), 4'b0101);
        drive(0, 0, 0, 0, 0, 0, 1, 4'b0101);
        chk("next_cyc_pass", int'(mismatch), 0);

        // Load priority over dut_reset/step; check judged against old exp.
        drive(0, 1, 4'b0110, 1, 1, 1, 1, 4'b0101);
        chk("load_prio", int'(exp), 4'b0110);
        chk("old_exp_pass", int'(mismatch), 0);

        // Four wrong checks reach the fault limit; a fifth is ignored.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 4'b1111);
            chk("fault_pulse", int'(mismatch), 1);
        end
        chk("fault_err", int'(err_count), 4);
        chk("fault_set", int'(fault), 1);
        drive(0, 0, 0, 0, 0, 0, 1, 4'b1111);
        chk("fault_nopulse", int'(mismatch), 0);
        chk("fault_frozen", int'(err_count), 4);
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        chk("fault_tracks", int'(exp), 4'b1100);

        // Reset out of FAULT.
        drive(1, 1, 4'b1000, 0, 1, 1, 1, 0);
        chk("clr_fault", int'(fault), 0);
        chk("clr_err", int'(err_count), 0);
        chk("clr_exp", int'(exp), 1);
        chk("clr_synced", int'(synced), 0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            bit r, l, dr, s, m, c;
            int d, o;
            r  = ($urandom_range(0, 79) == 0);
            l  = ($urandom_range(0, 7) == 0);
            dr = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 1) == 1);
            m  = 1'($urandom_range(0, 1));
            c  = ($urandom_range(0, 3) != 0);
            d  = int'($urandom_range(0, MODV - 1));
            o  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, MODV - 1)) : m_exp;
            drive(r, l, d, dr, s, m, c, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
